sub_bytes: RTL and testbench



---
 rtl/sub_bytes.sv | 71 +++++++
 tb/tb_sub_bytes.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes.sv
// AES SubBytes: byte-wise FIPS-197 S-box substitution, registered, one-cycle latency.
// Define SUB_BYTES_INV_EN to add the inv port and the inverse S-box table.
module sub_bytes #(
  parameter int unsigned DATA_LEN = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
`ifdef SUB_BYTES_INV_EN
  input  logic                inv,
`endif
  input  logic [DATA_LEN-1:0] data_in,
  output logic                valid_out,
  output logic [DATA_LEN-1:0] data_out
);

  localparam int unsigned NBYTES = DATA_LEN / 8;

  // Entry 0 sits in the most significant byte of each table.
  localparam logic [2047:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
`endif

  logic [DATA_LEN-1:0] sub;

  always_comb begin
    sub = '0;
    for (int unsigned k = 0; k < NBYTES; k++) begin
`ifdef SUB_BYTES_INV_EN
      if (inv)
        sub[8*k +: 8] = INV_SBOX[(255 - 32'(data_in[8*k +: 8])) * 8 +: 8];
      else
        sub[8*k +: 8] = FWD_SBOX[(255 - 32'(data_in[8*k +: 8])) * 8 +: 8];
`else
      sub[8*k +: 8] = FWD_SBOX[(255 - 32'(data_in[8*k +: 8])) * 8 +: 8];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in)
        data_out <= sub;
    end
  end

endmodule

// File: tb/tb_sub_bytes.sv
// Self-checking bench for sub_bytes; the reference S-box is derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [127:0] data_in;
  logic         valid_out;
  logic [127:0] data_out;
`ifdef SUB_BYTES_INV_EN
  logic         inv;
`endif

  sub_bytes #(.DATA_LEN(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
`ifdef SUB_BYTES_INV_EN
    .inv       (inv),
`endif
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  int unsigned  n_cmp  = 0;
  int unsigned  n_fail = 0;
  logic [127:0] sb_q[$];
  logic [127:0] exp_d;
  logic [127:0] held;
  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] a);
    logic [7:0] r, base, e;
    r = 8'h01; base = a; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    if (a == 8'h00) r = 8'h00;
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] d, input logic i);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = i ? inv_tab[d[8*k +: 8]] : fwd_tab[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic drive(input logic v, input logic [127:0] d, input logic i);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
`ifdef SUB_BYTES_INV_EN
    inv = i;
`endif
    if (v) sb_q.push_back(model_state(d, i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = rand128();
      tick();
      n_cmp++;
      if (valid_out !== 1'b0 || data_out !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: valid_out=%b data_out=%h want 0/0", valid_out, data_out);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    valid_in = 1'b0;
    drive(1'b1, rand128(), 1'b0);
    tick();
    n_cmp++;
    exp_d = sb_q.pop_front();
    if (valid_out !== 1'b1 || data_out !== exp_d) begin
      n_fail++;
      $display("FAIL reset_release: valid_out=%b data_out=%h want 1/%h", valid_out, data_out, exp_d);
    end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_async: valid_out=%b data_out=%h want 0/0", valid_out, data_out);
    end
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    valid_in = 1'b0;
    tick();
    n_cmp++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_no_carry: valid_out=%b data_out=%h want 0/0", valid_out, data_out);
    end
    held = '0;
  endtask

  task automatic test_single();
    drive(1'b1, 128'h00112233445566778899AABBCCDDEEFF, 1'b0);
    tick();
    exp_d = sb_q.pop_front();
    held = exp_d;
    n_cmp++;
    if (valid_out !== 1'b1 || data_out !== exp_d) begin
      n_fail++;
      $display("FAIL single_model: valid_out=%b data_out=%h want 1/%h", valid_out, data_out, exp_d);
    end
    n_cmp++;
    if (data_out !== 128'h638293C31BFC33F5C4EEACEA4BC12816) begin
      n_fail++;
      $display("FAIL single_const: data_out=%h want 638293c31bfc33f5c4eeacea4bc12816", data_out);
    end
    drive(1'b0, rand128(), 1'b0);
    tick();
    n_cmp++;
    if (valid_out !== 1'b0 || data_out !== held) begin
      n_fail++;
      $display("FAIL single_hold: valid_out=%b data_out=%h want 0/%h", valid_out, data_out, held);
    end
  endtask

  task automatic test_known();
    logic [127:0] ins  [3];
    logic [127:0] outs [3];
    ins[0] = 128'h2B7E151628AED2A6ABF7158809CF4F3C; outs[0] = 128'hF1F3594734E4B524626859C4018A84EB;
    ins[1] = '0;                                     outs[1] = {16{8'h63}};
    ins[2] = '1;                                     outs[2] = {16{8'h16}};
    for (int v = 0; v < 3; v++) begin
      drive(1'b1, ins[v], 1'b0);
      tick();
      exp_d = sb_q.pop_front();
      held = exp_d;
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== outs[v] || data_out !== exp_d) begin
        n_fail++;
        $display("FAIL known_%0d: valid_out=%b data_out=%h want 1/%h", v, valid_out, data_out, outs[v]);
      end
    end
    drive(1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] ins [4];
    ins[0] = 128'h0F1571C947D9E8590CB7ADD6AF7F6798;
    ins[1] = 128'hA1B2C3D4E5F60718293A4B5C6D7E8F90;
    ins[2] = rand128();
    ins[3] = rand128();
    for (int v = 0; v < 4; v++) begin
      drive(1'b1, ins[v], 1'b0);
      tick();
      exp_d = sb_q.pop_front();
      held = exp_d;
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== exp_d) begin
        n_fail++;
        $display("FAIL stream_%0d: valid_out=%b data_out=%h want 1/%h", v, valid_out, data_out, exp_d);
      end
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, rand128(), 1'b0);
      tick();
      n_cmp++;
      if (valid_out !== 1'b0 || data_out !== held) begin
        n_fail++;
        $display("FAIL stream_fall_%0d: valid_out=%b data_out=%h want 0/%h", c, valid_out, data_out, held);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [127:0] d;
    for (int v = 0; v < 256; v++) begin
      for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'((v + 17 * k) % 256);
      drive(1'b1, d, 1'b0);
      tick();
      exp_d = sb_q.pop_front();
      held = exp_d;
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== exp_d) begin
        n_fail++;
        $display("FAIL sweep_%0d: valid_out=%b data_out=%h want 1/%h", v, valid_out, data_out, exp_d);
      end
    end
    drive(1'b0, '0, 1'b0);
    tick();
  endtask

`ifdef SUB_BYTES_INV_EN
  task automatic test_inv();
    drive(1'b1, 128'h638293C31BFC33F5C4EEACEA4BC12816, 1'b1);
    tick();
    exp_d = sb_q.pop_front();
    n_cmp++;
    if (valid_out !== 1'b1 || data_out !== 128'h00112233445566778899AABBCCDDEEFF || data_out !== exp_d) begin
      n_fail++;
      $display("FAIL inv_const: valid_out=%b data_out=%h want 1/00112233445566778899aabbccddeeff", valid_out, data_out);
    end
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, rand128(), 1'(c % 2));
      tick();
      exp_d = sb_q.pop_front();
      held = exp_d;
      n_cmp++;
      if (valid_out !== 1'b1 || data_out !== exp_d) begin
        n_fail++;
        $display("FAIL inv_toggle_%0d: valid_out=%b data_out=%h want 1/%h", c, valid_out, data_out, exp_d);
      end
    end
    drive(1'b0, rand128(), 1'b1);
    tick();
    n_cmp++;
    if (valid_out !== 1'b0 || data_out !== held) begin
      n_fail++;
      $display("FAIL inv_hold: valid_out=%b data_out=%h want 0/%h", valid_out, data_out, held);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) fwd_tab[i] = model_sbox(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
`ifdef SUB_BYTES_INV_EN
    inv = 1'b0;
`endif
    #2;
    n_cmp++;
    if (valid_out !== 1'b0 || data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: valid_out=%b data_out=%h want 0/0", valid_out, data_out);
    end
    test_reset();
    test_single();
    test_known();
    test_back_to_back();
    test_exhaustive();
`ifdef SUB_BYTES_INV_EN
    test_inv();
`endif
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
